// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI-to-bank front-end.
//   resp_t  : AXI response codes (OKAY, SLVERR)
//   burst_t : AXI burst types understood by the port (FIXED, INCR)
//   state_t : front-end FSM states
package axi_mem_pkg;

    typedef logic [1:0] resp_t;
    localparam resp_t OKAY   = 2'b00;
    localparam resp_t SLVERR = 2'b10;

    typedef logic [1:0] burst_t;
    localparam burst_t FIXED = 2'b00;
    localparam burst_t INCR  = 2'b01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_CAP  = 3'd4,
        RD_DATA = 3'd5
    } state_t;

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way round-robin arbiter between the AW (write) and AR (read) channels.
// Ports:
//   clk, arst_n           : clock, asynchronous active-low reset
//   i_en                  : arbitration allowed this cycle (front-end idle)
//   i_req_w, i_req_r      : awvalid / arvalid
//   o_grant_w, o_grant_r  : one-hot (or zero) grants, used directly as ready
// The grant is combinational; because an AXI valid stays high until ready,
// a grant is always a handshake, so last_grant updates on the grant itself.
module axi_rr_arb2 (
    input  logic clk,
    input  logic arst_n,
    input  logic i_en,
    input  logic i_req_w,
    input  logic i_req_r,
    output logic o_grant_w,
    output logic o_grant_r
);

    // 1 = write won the most recent grant; resets to "read" so the first
    // collision goes to the write side.
    logic r_last_w;

    always_comb begin
        o_grant_w = 1'b0;
        o_grant_r = 1'b0;
        if (i_en) begin
            if (i_req_w && i_req_r) begin
                o_grant_w = !r_last_w;
                o_grant_r = r_last_w;
            end else begin
                o_grant_w = i_req_w;
                o_grant_r = i_req_r;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_last_w <= 1'b0;
        end else if (o_grant_w) begin
            r_last_w <= 1'b1;
        end else if (o_grant_r) begin
            r_last_w <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_bank_port.sv
// AXI4 subordinate front-end for one 4 KB single-ported memory bank.
// Converts AXI read/write bursts into one bank access per row and returns
// B / R responses. One burst is in flight at a time.
// Ports:
//   clk, arst_n                      : clock, asynchronous active-low reset
//   aw*/w*/b*                        : AXI write address, data, response
//   ar*/r*                           : AXI read address, data
//   bank_cs/we/row/wdata/wstrb       : bank command (bank writes on cs & wstrb)
//   bank_rdata                       : bank read data, valid the cycle after a read
//   dbg_state                        : current FSM state for observation
// Handshake rule on every channel: a transfer happens in a cycle where both
// valid and ready are 1; a source holds valid and its payload stable until
// that cycle. awready/arready are combinational from the valids in IDLE.
module axi_bank_port
    import axi_mem_pkg::*;
#(
    parameter int SIZE = 7,
    parameter int ID_W = 4
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [ID_W-1:0]          awid,
    input  logic [11:0]              awaddr,
    input  logic [7:0]               awlen,
    input  logic [1:0]               awburst,
    input  logic                     wvalid,
    output logic                     wready,
    input  logic [(2**SIZE)*8-1:0]   wdata,
    input  logic [(2**SIZE)-1:0]     wstrb,
    input  logic                     wlast,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [ID_W-1:0]          bid,
    output logic [1:0]               bresp,
    input  logic                     arvalid,
    output logic                     arready,
    input  logic [ID_W-1:0]          arid,
    input  logic [11:0]              araddr,
    input  logic [7:0]               arlen,
    input  logic [1:0]               arburst,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [ID_W-1:0]          rid,
    output logic [(2**SIZE)*8-1:0]   rdata,
    output logic [1:0]               rresp,
    output logic                     rlast,
    output logic                     bank_cs,
    output logic                     bank_we,
    output logic [11-SIZE:0]         bank_row,
    output logic [(2**SIZE)*8-1:0]   bank_wdata,
    output logic [(2**SIZE)-1:0]     bank_wstrb,
    input  logic [(2**SIZE)*8-1:0]   bank_rdata,
    output logic [2:0]               dbg_state
);

    localparam int ROW_W  = 12 - SIZE;
    localparam int DATA_W = (2**SIZE) * 8;

    state_t              r_state;
    state_t              w_next;
    logic [ID_W-1:0]     r_id;
    logic [ROW_W-1:0]    r_row;
    logic [8:0]          r_beats;     // beats remaining, 1..256
    logic                r_incr;
    logic                r_illegal;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;

    logic w_arb_en;
    logic w_aw_hs;
    logic w_ar_hs;
    logic w_w_hs;
    logic w_r_hs;
    logic w_last_beat;

    // Byte-offset bits inside a row carry no information for this bank.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = &{1'b0, awaddr[SIZE-1:0], araddr[SIZE-1:0]};

    // Gated with reset so the readys read 0 while reset is held.
    assign w_arb_en = (r_state == IDLE) && arst_n;

    axi_rr_arb2 u_arb (
        .clk       (clk),
        .arst_n    (arst_n),
        .i_en      (w_arb_en),
        .i_req_w   (awvalid),
        .i_req_r   (arvalid),
        .o_grant_w (awready),
        .o_grant_r (arready)
    );

    assign w_aw_hs     = awvalid && awready;
    assign w_ar_hs     = arvalid && arready;
    assign w_w_hs      = wvalid && wready;
    assign w_r_hs      = rvalid && rready;
    assign w_last_beat = (r_beats == 9'd1);

    assign bid        = r_id;
    assign rid        = r_id;
    assign rdata      = r_rdata;
    assign bank_wdata = wdata;
    assign dbg_state  = r_state;

    always_comb begin
        w_next     = r_state;
        wready     = 1'b0;
        bvalid     = 1'b0;
        bresp      = OKAY;
        rvalid     = 1'b0;
        rresp      = OKAY;
        rlast      = 1'b0;
        bank_cs    = 1'b0;
        bank_we    = 1'b0;
        bank_row   = '0;
        bank_wstrb = '0;
        case (r_state)
            IDLE: begin
                if (w_aw_hs) begin
                    w_next = WR_DATA;
                end else if (w_ar_hs) begin
                    w_next = RD_REQ;
                end
            end
            WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    bank_cs  = 1'b1;
                    bank_we  = 1'b1;
                    bank_row = r_row;
                    // Illegal bursts still walk the beats but never touch memory.
                    bank_wstrb = r_illegal ? '0 : wstrb;
                    if (w_last_beat) begin
                        w_next = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                bresp  = (r_illegal || r_err) ? SLVERR : OKAY;
                if (bready) begin
                    w_next = IDLE;
                end
            end
            RD_REQ: begin
                bank_cs  = 1'b1;
                bank_row = r_row;
                w_next   = RD_CAP;
            end
            RD_CAP: begin
                w_next = RD_DATA;
            end
            RD_DATA: begin
                rvalid = 1'b1;
                rlast  = w_last_beat;
                rresp  = r_illegal ? SLVERR : OKAY;
                if (rready) begin
                    w_next = w_last_beat ? IDLE : RD_REQ;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= IDLE;
            r_id      <= '0;
            r_row     <= '0;
            r_beats   <= '0;
            r_incr    <= 1'b0;
            r_illegal <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next;
            if (w_aw_hs) begin
                r_id      <= awid;
                r_row     <= awaddr[11:SIZE];
                r_beats   <= {1'b0, awlen} + 9'd1;
                r_incr    <= (awburst == INCR);
                r_illegal <= awburst[1];
                r_err     <= 1'b0;
            end else if (w_ar_hs) begin
                r_id      <= arid;
                r_row     <= araddr[11:SIZE];
                r_beats   <= {1'b0, arlen} + 9'd1;
                r_incr    <= (arburst == INCR);
                r_illegal <= arburst[1];
                r_err     <= 1'b0;
            end
            if (w_w_hs) begin
                // awlen, not wlast, ends the burst; a disagreeing wlast is an error.
                if (wlast != w_last_beat) begin
                    r_err <= 1'b1;
                end
                r_beats <= r_beats - 9'd1;
                if (r_incr) begin
                    r_row <= r_row + 1'b1;
                end
            end
            if (r_state == RD_CAP) begin
                r_rdata <= bank_rdata;
            end
            if (w_r_hs) begin
                r_beats <= r_beats - 9'd1;
                if (r_incr) begin
                    r_row <= r_row + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_bank_port.sv
// Self-checking bench for axi_bank_port: bank behavioural model, reference
// memory updated from AXI burst rules, and a read-data expected queue.
module tb_axi_bank_port;
    import axi_mem_pkg::*;

    localparam int SIZE  = 7;
    localparam int ID_W  = 4;
    localparam int ROW_W = 12 - SIZE;
    localparam int NROWS = 2**ROW_W;
    localparam int DW    = (2**SIZE) * 8;
    localparam int SW    = 2**SIZE;

    logic              clk;
    logic              arst_n;
    logic              awvalid, awready;
    logic [ID_W-1:0]   awid;
    logic [11:0]       awaddr;
    logic [7:0]        awlen;
    logic [1:0]        awburst;
    logic              wvalid, wready;
    logic [DW-1:0]     wdata;
    logic [SW-1:0]     wstrb;
    logic              wlast;
    logic              bvalid, bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              arvalid, arready;
    logic [ID_W-1:0]   arid;
    logic [11:0]       araddr;
    logic [7:0]        arlen;
    logic [1:0]        arburst;
    logic              rvalid, rready;
    logic [ID_W-1:0]   rid;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              bank_cs, bank_we;
    logic [ROW_W-1:0]  bank_row;
    logic [DW-1:0]     bank_wdata;
    logic [SW-1:0]     bank_wstrb;
    logic [DW-1:0]     bank_rdata;
    logic [2:0]        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 0;

    logic [DW-1:0] bank_mem [NROWS];
    logic [DW-1:0] ref_mem  [NROWS];
    logic [DW-1:0] exp_q[$];

    axi_bank_port #(.SIZE(SIZE), .ID_W(ID_W)) dut (
        .clk(clk), .arst_n(arst_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast),
        .bank_cs(bank_cs), .bank_we(bank_we), .bank_row(bank_row),
        .bank_wdata(bank_wdata), .bank_wstrb(bank_wstrb), .bank_rdata(bank_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bank model ----------------
    initial begin
        for (int r = 0; r < NROWS; r++) begin
            bank_mem[r] = '0;
            ref_mem[r]  = '0;
        end
        bank_rdata = '0;
    end

    always @(posedge clk) begin
        if (bank_cs) begin
            for (int i = 0; i < SW; i++) begin
                if (bank_wstrb[i]) bank_mem[bank_row][i*8 +: 8] <= bank_wdata[i*8 +: 8];
            end
            if (!bank_we) bank_rdata <= bank_mem[bank_row];
        end
    end

    // ---------------- invariant monitor ----------------
    always @(negedge clk) begin
        if (mon_en && arst_n) begin
            n_checks++;
            if ((!bank_cs || !bank_we) && (bank_wstrb !== '0)) begin
                n_fail++;
                $display("FAIL wstrb_gate: cs=%b we=%b wstrb=%h, required wstrb=0", bank_cs, bank_we, bank_wstrb);
            end
            n_checks++;
            if (awready === 1'b1 && arready === 1'b1) begin
                n_fail++;
                $display("FAIL dual_accept: awready=1 arready=1, required at most one");
            end
        end
    end

    // ---------------- helpers (stimulus / model arithmetic) ----------------
    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [SW-1:0] rand_strb();
        logic [SW-1:0] v;
        for (int i = 0; i < SW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] row, input logic [1:0] burst);
        int r;
        r = int'(row);
        if (burst == 2'b01) r = (r + 1) % NROWS;
        return r[ROW_W-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic aw_phase(input logic [ID_W-1:0] id, input logic [11:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        bit got;
        got = 0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (awready === 1'b1) got = 1;
            @(negedge clk);
        end
        awvalid = 1'b0;
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL aw_handshake: awready=0, required 1 within 40 cycles"); end
    endtask

    task automatic ar_phase(input logic [ID_W-1:0] id, input logic [11:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        bit got;
        got = 0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (arready === 1'b1) got = 1;
            @(negedge clk);
        end
        arvalid = 1'b0;
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL ar_handshake: arready=0, required 1 within 40 cycles"); end
    endtask

    task automatic w_beat(input logic [ROW_W-1:0] row, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input logic last, input bit legal);
        bit got;
        logic [SW-1:0] exp_strb;
        got = 0;
        exp_strb = legal ? strb : '0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (wready === 1'b1) begin
                got = 1;
                n_checks++;
                if ({bank_cs, bank_we} !== 2'b11) begin
                    n_fail++; $display("FAIL w_bank_cmd: cs,we=%b, required 11", {bank_cs, bank_we});
                end
                n_checks++;
                if (bank_row !== row) begin
                    n_fail++; $display("FAIL w_bank_row: row=%0d, required %0d", bank_row, row);
                end
                n_checks++;
                if (bank_wstrb !== exp_strb) begin
                    n_fail++; $display("FAIL w_bank_wstrb: wstrb=%h, required %h", bank_wstrb, exp_strb);
                end
            end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL w_handshake: wready=0, required 1 within 40 cycles"); end
        if (got && legal) begin
            for (int i = 0; i < SW; i++) if (strb[i]) ref_mem[row][i*8 +: 8] = data[i*8 +: 8];
        end
    endtask

    // data_mode 0: beat index as data, 1: random data
    task automatic w_b_phase(input logic [ID_W-1:0] id, input logic [11:0] addr,
                             input logic [7:0] len, input logic [1:0] burst,
                             input bit bad_wlast, input int data_mode, input bit use_rand_strb);
        logic [ROW_W-1:0] row;
        logic [DW-1:0]    data;
        logic [SW-1:0]    strb;
        logic [1:0]       exp_resp;
        logic             last;
        int               k;
        row = addr[11:SIZE];
        for (int b = 0; b <= int'(len); b++) begin
            data = (data_mode == 0) ? DW'(b) : rand_word();
            strb = use_rand_strb ? rand_strb() : '1;
            last = (b == int'(len)) && !bad_wlast;
            w_beat(row, data, strb, last, !burst[1]);
            row = next_row(row, burst);
        end
        exp_resp = (burst[1] || bad_wlast) ? 2'b10 : 2'b00;
        n_checks++;
        if (bvalid !== 1'b1) begin n_fail++; $display("FAIL b_latency: bvalid=%b one cycle after last W, required 1", bvalid); end
        for (int c = 0; c < 40 && bvalid !== 1'b1; c++) @(negedge clk);
        k = $urandom_range(0, 2);
        repeat (k) begin
            n_checks++;
            if (bvalid !== 1'b1) begin n_fail++; $display("FAIL b_hold: bvalid=%b while bready=0, required 1", bvalid); end
            @(negedge clk);
        end
        bready = 1'b1;
        n_checks++;
        if (bid !== id) begin n_fail++; $display("FAIL bid: bid=%h, required %h", bid, id); end
        n_checks++;
        if (bresp !== exp_resp) begin n_fail++; $display("FAIL bresp: bresp=%b, required %b", bresp, exp_resp); end
        @(negedge clk);
        bready = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0) begin n_fail++; $display("FAIL b_drop: bvalid=%b after handshake, required 0", bvalid); end
    endtask

    // Called at the negedge right after the AR handshake (cycle 1).
    // ready_mode 0: rready immediately, 1: random stalls, 2: stall 2 cycles on even beats
    task automatic r_phase(input logic [ID_W-1:0] id, input logic [11:0] addr,
                           input logic [7:0] len, input logic [1:0] burst, input int ready_mode);
        logic [ROW_W-1:0] row;
        logic [1:0]       exp_resp;
        int               k;
        bit               ok;
        row = addr[11:SIZE];
        exp_q.delete();
        for (int b = 0; b <= int'(len); b++) begin
            exp_q.push_back(ref_mem[row]);
            row = next_row(row, burst);
        end
        exp_resp = burst[1] ? 2'b10 : 2'b00;
        n_checks++;
        if ({bank_cs, bank_we, rvalid} !== 3'b100 || bank_row !== addr[11:SIZE]) begin
            n_fail++;
            $display("FAIL r_bank_req: cs,we,rvalid=%b row=%0d, required 100 row=%0d",
                     {bank_cs, bank_we, rvalid}, bank_row, addr[11:SIZE]);
        end
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0) begin n_fail++; $display("FAIL r_early: rvalid=%b in cycle 2, required 0", rvalid); end
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1) begin n_fail++; $display("FAIL r_latency: rvalid=%b in cycle 3, required 1", rvalid); end
        for (int b = 0; b <= int'(len); b++) begin
            ok = 0;
            for (int c = 0; c < 40 && !ok; c++) begin
                if (rvalid === 1'b1) ok = 1;
                else @(negedge clk);
            end
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL r_timeout: rvalid=0, required 1 within 40 cycles");
                return;
            end
            k = (ready_mode == 1) ? $urandom_range(0, 2) : (ready_mode == 2 && b % 2 == 0) ? 2 : 0;
            repeat (k) begin
                rready = 1'b0;
                n_checks++;
                if (rvalid !== 1'b1 || rdata !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL r_hold: rvalid=%b rdata[63:0]=%h, required 1 %h", rvalid, rdata[63:0], exp_q[0][63:0]);
                end
                @(negedge clk);
            end
            rready = 1'b1;
            n_checks++;
            if (rdata !== exp_q[0]) begin
                n_fail++; $display("FAIL rdata beat %0d: rdata[63:0]=%h, required %h", b, rdata[63:0], exp_q[0][63:0]);
            end
            n_checks++;
            if (rlast !== (b == int'(len))) begin
                n_fail++; $display("FAIL rlast beat %0d: rlast=%b, required %b", b, rlast, (b == int'(len)));
            end
            n_checks++;
            if (rid !== id || rresp !== exp_resp) begin
                n_fail++; $display("FAIL rid_rresp: rid=%h rresp=%b, required %h %b", rid, rresp, id, exp_resp);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
            rready = 1'b0;
        end
        n_checks++;
        if (rvalid !== 1'b0) begin n_fail++; $display("FAIL r_drop: rvalid=%b after last beat, required 0", rvalid); end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        arst_n = 1'b0;
        awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({awready, arready, wready, bvalid, rvalid, bank_cs, bank_we, bank_row, bank_wstrb,
             bresp, rresp, rlast, bid, rid} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: some control output nonzero, required all 0");
        end
        n_checks++;
        if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: rdata[63:0]=%h, required 0", rdata[63:0]); end
        n_checks++;
        if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: state=%0d, required 0 (IDLE)", dbg_state); end
        awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        mon_en = 1;
        @(negedge clk);
    endtask

    task automatic test_incr_write();
        aw_phase(4'h3, 12'h080, 8'd3, INCR);
        w_b_phase(4'h3, 12'h080, 8'd3, INCR, 0, 0, 0);
        for (int r = 1; r <= 4; r++) begin
            n_checks++;
            if (bank_mem[r] !== DW'(r - 1)) begin
                n_fail++; $display("FAIL incr_row %0d: mem[63:0]=%h, required %0d", r, bank_mem[r][63:0], r - 1);
            end
        end
    endtask

    task automatic test_incr_read();
        ar_phase(4'h9, 12'h080, 8'd3, INCR);
        r_phase(4'h9, 12'h080, 8'd3, INCR, 2);
    endtask

    task automatic test_fixed_wrap();
        aw_phase(4'h4, 12'h280, 8'd1, FIXED);
        w_b_phase(4'h4, 12'h280, 8'd1, FIXED, 0, 1, 0);
        aw_phase(4'h5, 12'hF80, 8'd1, INCR);
        w_b_phase(4'h5, 12'hF80, 8'd1, INCR, 0, 1, 0);
        for (int r = 0; r < NROWS; r++) begin
            n_checks++;
            if (bank_mem[r] !== ref_mem[r]) begin
                n_fail++; $display("FAIL fixed_wrap_mem row %0d: mem[63:0]=%h, required %h", r, bank_mem[r][63:0], ref_mem[r][63:0]);
            end
        end
        ar_phase(4'h6, 12'h280, 8'd0, FIXED);
        r_phase(4'h6, 12'h280, 8'd0, FIXED, 1);
        ar_phase(4'h7, 12'hF80, 8'd1, INCR);
        r_phase(4'h7, 12'hF80, 8'd1, INCR, 1);
    endtask

    task automatic test_illegal();
        aw_phase(4'hA, 12'h300, 8'd0, 2'b10);
        w_b_phase(4'hA, 12'h300, 8'd0, 2'b10, 0, 1, 0);
        for (int r = 0; r < NROWS; r++) begin
            n_checks++;
            if (bank_mem[r] !== ref_mem[r]) begin
                n_fail++; $display("FAIL illegal_mem row %0d: mem[63:0]=%h, required %h", r, bank_mem[r][63:0], ref_mem[r][63:0]);
            end
        end
        aw_phase(4'hB, 12'h300, 8'd1, INCR);
        w_b_phase(4'hB, 12'h300, 8'd1, INCR, 1, 1, 1);
        ar_phase(4'hC, 12'h300, 8'd0, 2'b11);
        r_phase(4'hC, 12'h300, 8'd0, 2'b11, 0);
    endtask

    task automatic test_collision();
        awid = 4'h1; awaddr = 12'h400; awlen = 8'd1; awburst = INCR; awvalid = 1'b1;
        arid = 4'h2; araddr = 12'h080; arlen = 8'd0; arburst = INCR; arvalid = 1'b1;
        #1;
        n_checks++;
        if ({awready, arready} !== 2'b10) begin
            n_fail++; $display("FAIL collide_1: awready,arready=%b, required 10", {awready, arready});
        end
        @(negedge clk);
        awvalid = 1'b0;
        w_b_phase(4'h1, 12'h400, 8'd1, INCR, 0, 1, 1);
        awid = 4'h5; awaddr = 12'h500; awlen = 8'd0; awburst = INCR; awvalid = 1'b1;
        #1;
        n_checks++;
        if ({awready, arready} !== 2'b01) begin
            n_fail++; $display("FAIL collide_2: awready,arready=%b, required 01", {awready, arready});
        end
        @(negedge clk);
        arvalid = 1'b0;
        r_phase(4'h2, 12'h080, 8'd0, INCR, 0);
        aw_phase(4'h5, 12'h500, 8'd0, INCR);
        w_b_phase(4'h5, 12'h500, 8'd0, INCR, 0, 1, 0);
    endtask

    task automatic test_reset_mid_burst();
        logic [DW-1:0] d1;
        d1 = rand_word();
        aw_phase(4'h7, 12'h600, 8'd3, INCR);
        w_beat(5'd12, d1, '1, 1'b0, 1);
        wdata = rand_word(); wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
        arst_n = 1'b0;
        #1;
        n_checks++;
        if ({awready, arready, wready, bvalid, rvalid, bank_cs, bank_we, bank_row, bank_wstrb,
             bresp, rresp, rlast, bid, rid} !== '0 || rdata !== '0) begin
            n_fail++; $display("FAIL midburst_reset: outputs nonzero during reset, required all 0");
        end
        wvalid = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bank_mem[13] !== ref_mem[13]) begin
            n_fail++; $display("FAIL midburst_row13: mem[63:0]=%h, required %h", bank_mem[13][63:0], ref_mem[13][63:0]);
        end
        ar_phase(4'h8, 12'h600, 8'd0, INCR);
        r_phase(4'h8, 12'h600, 8'd0, INCR, 0);
    endtask

    task automatic test_random();
        logic [11:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [3:0]  id;
        for (int t = 0; t < 12; t++) begin
            addr  = 12'($urandom);
            len   = 8'($urandom_range(0, 5));
            burst = 2'($urandom_range(0, 1));
            id    = 4'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                aw_phase(id, addr, len, burst);
                w_b_phase(id, addr, len, burst, 0, 1, 1);
            end else begin
                ar_phase(id, addr, len, burst);
                r_phase(id, addr, len, burst, 1);
            end
        end
    endtask

    task automatic test_final_mem();
        for (int r = 0; r < NROWS; r++) begin
            n_checks++;
            if (bank_mem[r] !== ref_mem[r]) begin
                n_fail++; $display("FAIL final_mem row %0d: mem[63:0]=%h, required %h", r, bank_mem[r][63:0], ref_mem[r][63:0]);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        arst_n = 1'b0;
        awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awburst = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        bready = 1'b0;
        arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arburst = '0;
        rready = 1'b0;
        @(negedge clk);
        test_reset();
        test_incr_write();
        test_incr_read();
        test_fixed_wrap();
        test_illegal();
        test_collision();
        test_reset_mid_burst();
        test_random();
        test_final_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
